pipeline_wb_stage: RTL and testbench

Parametrised MEM/WB pipeline boundary register with integrated write-back selection. It captures the memory-stage results, control bits and destination register at each clock. It supports stall (hold) and flush (bubble insertion), freezes the pipeline tail once a Halt retires, and keeps a saturating retired-instruction counter. It sits between the data-memory stage and the register-file write port, and replaces the fixed-width MEM/WB register.

---
 rtl/pipeline_wb_stage.sv | 102 ++++++++++
 tb/tb_pipeline_wb_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_wb_stage.sv
// MEM/WB boundary register with write-back source selection, stall/flush,
// halt freeze and a saturating retired-instruction counter.
module pipeline_wb_stage #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int CTRL_W      = 4,
    parameter int CNT_W       = 16,
    parameter int ZERO_REG_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] dmem_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] dst_in,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              RegWrite,
    output logic              MemtoReg,
    output logic              PCtoReg,
    output logic              Halt,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_dst,
    output logic              wb_we,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_count
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_dmem;
    logic [DATA_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_dst;
    logic              r_halted;
    logic [CNT_W-1:0]  r_retired;

    logic              w_zero_block;
    logic              w_cnt_sat;

    assign w_cnt_sat = &r_retired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_alu     <= '0;
            r_dmem    <= '0;
            r_pc      <= '0;
            r_dst     <= '0;
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else if (!r_halted) begin
            if (flush) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
                r_alu   <= '0;
                r_dmem  <= '0;
                r_pc    <= '0;
                r_dst   <= '0;
            end else if (!stall) begin
                r_valid <= in_valid;
                // an invalid entry must not carry any control into write-back
                r_ctrl  <= in_ctrl & {CTRL_W{in_valid}};
                r_alu   <= alu_in;
                r_dmem  <= dmem_in;
                r_pc    <= pc_in;
                r_dst   <= dst_in;
                if (in_valid && in_ctrl[0])
                    r_halted <= 1'b1;
                if (in_valid && !w_cnt_sat)
                    r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign w_zero_block = (ZERO_REG_EN != 0) && (r_dst == '0);

    always_comb begin
        wb_data = r_alu;
        if (r_ctrl[1])
            wb_data = r_pc;
        else if (r_ctrl[2])
            wb_data = r_dmem;
    end

    assign valid_out     = r_valid;
    assign ctrl_out      = r_ctrl;
    assign RegWrite      = r_ctrl[3] & r_valid;
    assign MemtoReg      = r_ctrl[2] & r_valid;
    assign PCtoReg       = r_ctrl[1] & r_valid;
    assign Halt          = r_ctrl[0] & r_valid;
    assign wb_dst        = r_dst;
    assign wb_we         = r_valid & r_ctrl[3] & ~w_zero_block;
    assign halted        = r_halted;
    assign retired_count = r_retired;

endmodule

// File: tb/tb_pipeline_wb_stage.sv
// Bench for pipeline_wb_stage: directed vector table plus random traffic
// against a behavioural model; extra instances cover ZERO_REG_EN=0 and CNT_W=2.
module tb_pipeline_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [3:0]  in_ctrl;
    logic [15:0] alu_in, dmem_in, pc_in;
    logic [3:0]  dst_in;

    logic        valid_out, RegWrite, MemtoReg, PCtoReg, Halt, wb_we, halted;
    logic [3:0]  ctrl_out, wb_dst;
    logic [15:0] wb_data, retired_count;

    logic        nz_valid, nz_rw, nz_mr, nz_pr, nz_h, nz_we, nz_halted;
    logic [3:0]  nz_ctrl, nz_dst;
    logic [15:0] nz_data, nz_cnt;

    logic        sc_valid, sc_rw, sc_mr, sc_pr, sc_h, sc_we, sc_halted;
    logic [3:0]  sc_ctrl, sc_dst;
    logic [15:0] sc_data;
    logic [1:0]  sc_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_ctrl(in_ctrl), .alu_in(alu_in), .dmem_in(dmem_in), .pc_in(pc_in), .dst_in(dst_in),
        .valid_out(valid_out), .ctrl_out(ctrl_out), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .PCtoReg(PCtoReg), .Halt(Halt), .wb_data(wb_data), .wb_dst(wb_dst), .wb_we(wb_we),
        .halted(halted), .retired_count(retired_count)
    );

    pipeline_wb_stage #(.ZERO_REG_EN(0)) u_nz (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_ctrl(in_ctrl), .alu_in(alu_in), .dmem_in(dmem_in), .pc_in(pc_in), .dst_in(dst_in),
        .valid_out(nz_valid), .ctrl_out(nz_ctrl), .RegWrite(nz_rw), .MemtoReg(nz_mr),
        .PCtoReg(nz_pr), .Halt(nz_h), .wb_data(nz_data), .wb_dst(nz_dst), .wb_we(nz_we),
        .halted(nz_halted), .retired_count(nz_cnt)
    );

    pipeline_wb_stage #(.CNT_W(2)) u_sc (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_ctrl(in_ctrl), .alu_in(alu_in), .dmem_in(dmem_in), .pc_in(pc_in), .dst_in(dst_in),
        .valid_out(sc_valid), .ctrl_out(sc_ctrl), .RegWrite(sc_rw), .MemtoReg(sc_mr),
        .PCtoReg(sc_pr), .Halt(sc_h), .wb_data(sc_data), .wb_dst(sc_dst), .wb_we(sc_we),
        .halted(sc_halted), .retired_count(sc_cnt)
    );

    typedef struct {
        logic        rst, stall, flush, v;
        logic [3:0]  ctrl;
        logic [15:0] alu, dmem, pc;
        logic [3:0]  dst;
        logic        e_valid;
        logic [3:0]  e_ctrl;
        logic        e_we;
        logic [15:0] e_data;
        logic [3:0]  e_dst;
        logic        e_halted;
        logic [15:0] e_cnt;
    } vec_t;

    // behavioural model: the latched entry plus an unbounded retire tally
    logic        m_valid, m_halted;
    logic [3:0]  m_ctrl, m_dst;
    logic [15:0] m_alu, m_dmem, m_pc;
    int          m_retired;

    function automatic vec_t mk(logic r, logic s, logic f, logic v, logic [3:0] c,
                                logic [15:0] a, logic [15:0] d, logic [15:0] p, logic [3:0] ds,
                                logic ev, logic [3:0] ec, logic ew, logic [15:0] edata,
                                logic [3:0] edst, logic eh, logic [15:0] ecnt);
        vec_t t;
        t.rst = r; t.stall = s; t.flush = f; t.v = v; t.ctrl = c;
        t.alu = a; t.dmem = d; t.pc = p; t.dst = ds;
        t.e_valid = ev; t.e_ctrl = ec; t.e_we = ew; t.e_data = edata;
        t.e_dst = edst; t.e_halted = eh; t.e_cnt = ecnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_valid = 0; m_ctrl = 0; m_alu = 0; m_dmem = 0; m_pc = 0; m_dst = 0;
            m_halted = 0; m_retired = 0;
        end else if (m_halted) begin
        end else if (flush) begin
            m_valid = 0; m_ctrl = 0; m_alu = 0; m_dmem = 0; m_pc = 0; m_dst = 0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_ctrl  = in_valid ? in_ctrl : 4'h0;
            m_alu = alu_in; m_dmem = dmem_in; m_pc = pc_in; m_dst = dst_in;
            if (in_valid) begin
                m_retired++;
                if (in_ctrl[0]) m_halted = 1;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        logic [15:0] e_data;
        int          cap16, cap2;
        e_data = m_ctrl[1] ? m_pc : (m_ctrl[2] ? m_dmem : m_alu);
        cap16  = (m_retired > 65535) ? 65535 : m_retired;
        cap2   = (m_retired > 3) ? 3 : m_retired;
        chk("rnd_valid", valid_out, m_valid);
        chk("rnd_ctrl", ctrl_out, m_ctrl);
        chk("rnd_dec", {RegWrite, MemtoReg, PCtoReg, Halt}, m_valid ? m_ctrl : 4'h0);
        chk("rnd_data", wb_data, e_data);
        chk("rnd_dst", wb_dst, m_dst);
        chk("rnd_we", wb_we, m_valid && m_ctrl[3] && (m_dst != 0));
        chk("rnd_nz_we", nz_we, m_valid && m_ctrl[3]);
        chk("rnd_halted", halted, m_halted);
        chk("rnd_cnt", retired_count, cap16);
        chk("rnd_sc_cnt", sc_cnt, cap2);
    endtask

    vec_t tbl[15];

    initial begin
        tbl[0]  = mk(1,0,0,0, 4'h0, 16'h0000,16'h0000,16'h0000,4'd0,  0,4'h0,0,16'h0000,4'd0,0,16'd0);
        tbl[1]  = mk(0,0,0,1, 4'h8, 16'h1234,16'h0000,16'h0000,4'd3,  1,4'h8,1,16'h1234,4'd3,0,16'd1);
        tbl[2]  = mk(0,0,0,1, 4'hC, 16'h1111,16'hBEEF,16'h2222,4'd5,  1,4'hC,1,16'hBEEF,4'd5,0,16'd2);
        tbl[3]  = mk(0,0,0,1, 4'hA, 16'h1111,16'h3333,16'h0042,4'd6,  1,4'hA,1,16'h0042,4'd6,0,16'd3);
        tbl[4]  = mk(0,0,0,1, 4'hE, 16'h5555,16'h4444,16'h0077,4'd7,  1,4'hE,1,16'h0077,4'd7,0,16'd4);
        tbl[5]  = mk(0,1,0,1, 4'h8, 16'h9999,16'h8888,16'h7777,4'd2,  1,4'hE,1,16'h0077,4'd7,0,16'd4);
        tbl[6]  = mk(0,1,0,1, 4'h4, 16'h9998,16'h8887,16'h7776,4'd1,  1,4'hE,1,16'h0077,4'd7,0,16'd4);
        tbl[7]  = mk(0,1,0,0, 4'h2, 16'h9997,16'h8886,16'h7775,4'd9,  1,4'hE,1,16'h0077,4'd7,0,16'd4);
        tbl[8]  = mk(0,1,1,1, 4'h8, 16'hAAAA,16'hBBBB,16'hCCCC,4'd4,  0,4'h0,0,16'h0000,4'd0,0,16'd4);
        tbl[9]  = mk(0,0,0,1, 4'h8, 16'hABCD,16'h0000,16'h0000,4'd0,  1,4'h8,0,16'hABCD,4'd0,0,16'd5);
        tbl[10] = mk(0,0,0,0, 4'hF, 16'h0001,16'h0002,16'h0003,4'd2,  0,4'h0,0,16'h0001,4'd2,0,16'd5);
        tbl[11] = mk(0,0,0,1, 4'h1, 16'h0DEF,16'h0000,16'h0000,4'd9,  1,4'h1,0,16'h0DEF,4'd9,1,16'd6);
        tbl[12] = mk(0,0,0,1, 4'h8, 16'hFFFF,16'h0000,16'h0000,4'd1,  1,4'h1,0,16'h0DEF,4'd9,1,16'd6);
        tbl[13] = mk(0,0,1,0, 4'h0, 16'h0000,16'h0000,16'h0000,4'd0,  1,4'h1,0,16'h0DEF,4'd9,1,16'd6);
        tbl[14] = mk(1,0,0,1, 4'h8, 16'h1234,16'h0000,16'h0000,4'd3,  0,4'h0,0,16'h0000,4'd0,0,16'd0);

        rst = 1; stall = 0; flush = 0; in_valid = 0; in_ctrl = 0;
        alu_in = 0; dmem_in = 0; pc_in = 0; dst_in = 0;
        m_valid = 0; m_ctrl = 0; m_alu = 0; m_dmem = 0; m_pc = 0; m_dst = 0;
        m_halted = 0; m_retired = 0;
        step();

        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; stall = tbl[i].stall; flush = tbl[i].flush;
            in_valid = tbl[i].v; in_ctrl = tbl[i].ctrl; alu_in = tbl[i].alu;
            dmem_in = tbl[i].dmem; pc_in = tbl[i].pc; dst_in = tbl[i].dst;
            step();
            chk($sformatf("v%0d_valid", i), valid_out, tbl[i].e_valid);
            chk($sformatf("v%0d_ctrl", i), ctrl_out, tbl[i].e_ctrl);
            chk($sformatf("v%0d_halt_o", i), Halt, tbl[i].e_ctrl[0] & tbl[i].e_valid);
            chk($sformatf("v%0d_we", i), wb_we, tbl[i].e_we);
            chk($sformatf("v%0d_data", i), wb_data, tbl[i].e_data);
            chk($sformatf("v%0d_dst", i), wb_dst, tbl[i].e_dst);
            chk($sformatf("v%0d_halted", i), halted, tbl[i].e_halted);
            chk($sformatf("v%0d_cnt", i), retired_count, tbl[i].e_cnt);
            if (i == 2) chk("sc_cnt_2", sc_cnt, 2'd2);
            if (i == 9) begin
                chk("nz_we_dst0", nz_we, 1'b1);
                chk("sc_cnt_sat", sc_cnt, 2'd3);
            end
            if (i == 10) chk("sc_cnt_invalid", sc_cnt, 2'd3);
        end

        rst = 1; stall = 0; flush = 0; in_valid = 0;
        step();
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 39) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_ctrl  = {3'($urandom_range(0, 7)), ($urandom_range(0, 29) == 0)};
            alu_in   = 16'($urandom);
            dmem_in  = 16'($urandom);
            pc_in    = 16'($urandom);
            dst_in   = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            step();
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
